// File: rtl/hack_ctrl_seq.sv
// Hack CPU control sequencer: accepts one instruction at a time through a
// valid/ready handshake and steps it through EXEC/WB (C-instruction) or
// AWB (A-instruction). It drives the ALU control bits, the destination
// strobes, the jump request and a count of retired instructions.
module hack_ctrl_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic        zr,
  input  logic        ng,
  output logic        zx,
  output logic        nx,
  output logic        zy,
  output logic        ny,
  output logic        f,
  output logic        no,
  output logic        a_sel,
  output logic        write_a,
  output logic        write_d,
  output logic        write_m,
  output logic        load_a,
  output logic [15:0] a_imm,
  output logic        jump,
  output logic        illegal,
  output logic [15:0] retired
);

  typedef enum logic [1:0] {IDLE, EXEC, WB, AWB} state_t;

  state_t      state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic        zr_q, zr_d;
  logic        ng_q, ng_d;
  logic [15:0] retired_q, retired_d;

  logic        legal;
  logic        jump_raw;

  // State, latched instruction, EXEC-time flags and retire counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      instr_q   <= '0;
      zr_q      <= 1'b0;
      ng_q      <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      zr_q      <= zr_d;
      ng_q      <= ng_d;
      retired_q <= retired_d;
    end
  end

  // Next-state: accept only in IDLE, retire on the final cycle of each instruction.
  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    zr_d      = zr_q;
    ng_d      = ng_q;
    retired_d = retired_q;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
          state_d = instr[15] ? EXEC : AWB;
        end
      end
      EXEC: begin
        // Flags are captured here so WB sees the result of this instruction's ALU op.
        zr_d    = zr;
        ng_d    = ng;
        state_d = WB;
      end
      WB: begin
        retired_d = retired_q + 16'd1;
        state_d   = IDLE;
      end
      AWB: begin
        retired_d = retired_q + 16'd1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A C-instruction must carry 111 in its top three bits; jump uses the captured flags.
  assign legal    = instr_q[15] & (instr_q[14:13] == 2'b11);
  assign jump_raw = (instr_q[2] & ng_q) | (instr_q[1] & zr_q) | (instr_q[0] & ~ng_q & ~zr_q);
  assign retired  = retired_q;

  // Output decode: everything is quiet except in the state that owns it.
  always_comb begin
    instr_ready = (state_q == IDLE);
    {zx, nx, zy, ny, f, no} = 6'b0;
    a_sel   = 1'b0;
    write_a = 1'b0;
    write_d = 1'b0;
    write_m = 1'b0;
    load_a  = 1'b0;
    a_imm   = '0;
    jump    = 1'b0;
    illegal = 1'b0;
    case (state_q)
      AWB: begin
        load_a = 1'b1;
        a_imm  = {1'b0, instr_q[14:0]};
      end
      EXEC: begin
        {zx, nx, zy, ny, f, no} = instr_q[11:6];
        a_sel = instr_q[12];
      end
      WB: begin
        {zx, nx, zy, ny, f, no} = instr_q[11:6];
        a_sel = instr_q[12];
        if (legal) begin
          write_a = instr_q[5];
          write_d = instr_q[4];
          write_m = instr_q[3];
          jump    = jump_raw;
        end else begin
          illegal = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
